// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: turns bytes into start/data[/parity]/stop frames, one bit per baud_clk period.
// Latency: accept -> start bit on the first bit_tick after the accept cycle; each tx change lands 1 clk after its bit_tick.
// Backpressure: tx_ready is low from the cycle after accept until the cycle after the final stop tick; tx_valid is ignored meanwhile.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD selects odd sense).
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 baud_s1;
  logic                 baud_s2;
  logic                 baud_s3;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Synchronise the divider clock and emit a one-cycle tick on its rising edge (3 clk after the edge).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_s1  <= 1'b0;
      baud_s2  <= 1'b0;
      baud_s3  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      baud_s1  <= baud_clk;
      baud_s2  <= baud_s1;
      baud_s3  <= baud_s2;
      bit_tick <= baud_s2 & ~baud_s3;
    end
  end

  // Frame sequencer: every tx level change is registered one cycle after the tick that causes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift      <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= ARM;
          end
        end
        // A tick coinciding with the accept was consumed in IDLE, so ARM always waits for a fresh one.
        ARM: begin
          if (bit_tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx       <= parity_bit;
              state    <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              tx       <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
